// File: rtl/fast_store_pkg.sv
// Shared types and width helpers for the FAST template/previous-value store.
package fast_store_pkg;

  // FAST dictionary state of one previous value; UNDEF must stay all-zero
  // so that reset and dictionary clear can simply zero the state arrays.
  typedef enum logic [1:0] {
    ST_UNDEF    = 2'b00,
    ST_ASSIGNED = 2'b01,
    ST_EMPTY    = 2'b10
  } prev_state_e;

  // Output presentation state: PRESENT means out_valid is high.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } store_state_e;

  // Layout of a 10-bit field descriptor; all-zero means an unused field.
  typedef struct packed {
    logic [2:0] datatype;
    logic [2:0] op;
    logic       optional;
    logic       pmap;
    logic [1:0] field_num;
  } field_info_t;

  localparam int DEF_FIELD_INFO_W = $bits(field_info_t);

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int calc_tid_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_fidx_w(input int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fast_tid_pick.sv
// Priority selector: finds the lowest valid lane flagged as carrying the TID.
module fast_tid_pick
  import fast_store_pkg::*;
#(
  parameter int BEAT_W        = 64,
  parameter int NUM_PATHS     = 4,
  parameter int NUM_TEMPLATES = 4,
  parameter int TID_W         = 2,
  localparam int LANE_W       = calc_tid_w(NUM_PATHS)
) (
  input  logic [NUM_PATHS-1:0][BEAT_W-1:0] lane_data,
  input  logic [NUM_PATHS-1:0]             lane_valid,
  input  logic [NUM_PATHS-1:0]             lane_is_tid,
  output logic                             found,
  output logic [LANE_W-1:0]                lane_idx,
  output logic [TID_W-1:0]                 tid,
  output logic                             range_err
);

  logic [BEAT_W-1:0] sel_data;

  // Scan from the top lane down so the lowest matching lane wins.
  always_comb begin
    found    = 1'b0;
    lane_idx = '0;
    sel_data = '0;
    for (int i = NUM_PATHS - 1; i >= 0; i--) begin
      if (lane_valid[i] && lane_is_tid[i]) begin
        found    = 1'b1;
        lane_idx = LANE_W'(i);
        sel_data = lane_data[i];
      end
    end
    tid       = sel_data[TID_W-1:0];
    // Range is checked on the full beat, not on the truncated TID.
    range_err = found && (sel_data >= BEAT_W'(NUM_TEMPLATES));
  end

endmodule

// File: rtl/fast_template_store.sv
// FAST template/previous-value store: presents a template snapshot plus
// per-field dictionary values/states for each accepted message.
//
// Handshakes: the message side is accepted on msg_valid && msg_ready, with
// msg_ready = !out_valid || out_ready. The snapshot side holds out_valid and
// its data stable (apart from forwarded dictionary updates) until out_ready.
module fast_template_store
  import fast_store_pkg::*;
#(
  parameter int BEAT_W        = 64,
  parameter int NUM_TEMPLATES = 4,
  parameter int NUM_PATHS     = 4,
  parameter int FIELD_INFO_W  = 10,
  parameter int MAX_FIELDS    = 10,
  localparam int TID_W        = calc_tid_w(NUM_TEMPLATES),
  localparam int FIDX_W       = calc_fidx_w(MAX_FIELDS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   msg_valid,
  output logic                                   msg_ready,
  input  logic [NUM_PATHS-1:0][BEAT_W-1:0]       lane_data,
  input  logic [NUM_PATHS-1:0]                   lane_valid,
  input  logic [NUM_PATHS-1:0]                   lane_is_tid,
  input  logic                                   cfg_we,
  input  logic [TID_W-1:0]                       cfg_tid,
  input  logic [FIDX_W-1:0]                      cfg_fidx,
  input  logic [FIELD_INFO_W-1:0]                cfg_info,
  input  logic                                   upd_valid,
  input  logic [FIDX_W-1:0]                      upd_fidx,
  input  logic [BEAT_W-1:0]                      upd_value,
  input  logic                                   upd_empty,
  input  logic                                   dict_clear,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [TID_W-1:0]                       out_tid,
  output logic [MAX_FIELDS-1:0][FIELD_INFO_W-1:0] out_template,
  output logic [MAX_FIELDS-1:0][BEAT_W-1:0]      out_prev,
  output logic [MAX_FIELDS-1:0][1:0]             out_prev_state,
  output logic                                   err_tid
);

  localparam int LANE_W = calc_tid_w(NUM_PATHS);

  store_state_e state, state_nxt;

  logic [MAX_FIELDS-1:0][FIELD_INFO_W-1:0] tmpl_ram [NUM_TEMPLATES];
  logic [MAX_FIELDS-1:0][BEAT_W-1:0]       dict_val [NUM_TEMPLATES];
  logic [MAX_FIELDS-1:0][1:0]              dict_st  [NUM_TEMPLATES];

  logic [TID_W-1:0]  active_tid;
  logic              active_vld;

  logic              pick_found;
  logic [LANE_W-1:0] pick_lane;
  logic [TID_W-1:0]  pick_tid;
  logic              pick_range_err;

  logic accept, load, bad_tid, upd_hit, cfg_hit, fwd;

  fast_tid_pick #(
    .BEAT_W        (BEAT_W),
    .NUM_PATHS     (NUM_PATHS),
    .NUM_TEMPLATES (NUM_TEMPLATES),
    .TID_W         (TID_W)
  ) u_pick (
    .lane_data   (lane_data),
    .lane_valid  (lane_valid),
    .lane_is_tid (lane_is_tid),
    .found       (pick_found),
    .lane_idx    (pick_lane),
    .tid         (pick_tid),
    .range_err   (pick_range_err)
  );

  assign out_valid = (state == S_PRESENT);
  assign msg_ready = !out_valid || out_ready;
  assign accept    = msg_valid && msg_ready;
  assign load      = accept && pick_found && !pick_range_err;
  assign bad_tid   = accept && !(pick_found && !pick_range_err);
  // A dictionary clear swallows any same-cycle update entirely.
  assign upd_hit   = upd_valid && active_vld && !dict_clear &&
                     ({1'b0, upd_fidx} < (FIDX_W + 1)'(MAX_FIELDS));
  assign cfg_hit   = cfg_we &&
                     ({1'b0, cfg_tid} < (TID_W + 1)'(NUM_TEMPLATES)) &&
                     ({1'b0, cfg_fidx} < (FIDX_W + 1)'(MAX_FIELDS));
  // On a load, forward only if the update targets the slot being loaded.
  assign fwd       = load ? (upd_hit && (active_tid == pick_tid))
                          : (out_valid && upd_hit);

  // Presentation state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: a good accept always presents; otherwise hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (load) state_nxt = S_PRESENT;
      S_PRESENT: if (out_ready) state_nxt = load ? S_PRESENT : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Active TID tracking and the one-cycle bad-TID pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_tid <= '0;
      active_vld <= 1'b0;
      err_tid    <= 1'b0;
    end else begin
      err_tid <= bad_tid;
      if (load) begin
        active_tid <= pick_tid;
        active_vld <= 1'b1;
      end
    end
  end

  // Template RAM writes; a same-cycle load reads the pre-write descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TEMPLATES; t++) tmpl_ram[t] <= '0;
    end else if (cfg_hit) begin
      tmpl_ram[cfg_tid][cfg_fidx] <= cfg_info;
    end
  end

  // Dictionary: clear resets states only, updates target the active slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TEMPLATES; t++) begin
        dict_val[t] <= '0;
        dict_st[t]  <= '0;
      end
    end else if (dict_clear) begin
      for (int t = 0; t < NUM_TEMPLATES; t++) dict_st[t] <= '0;
    end else if (upd_hit) begin
      if (upd_empty) begin
        dict_st[active_tid][upd_fidx] <= ST_EMPTY;
      end else begin
        dict_val[active_tid][upd_fidx] <= upd_value;
        dict_st[active_tid][upd_fidx]  <= ST_ASSIGNED;
      end
    end
  end

  // Snapshot registers: load, then forward an update, then apply a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tid        <= '0;
      out_template   <= '0;
      out_prev       <= '0;
      out_prev_state <= '0;
    end else begin
      if (load) begin
        out_tid        <= pick_tid;
        out_template   <= tmpl_ram[pick_tid];
        out_prev       <= dict_val[pick_tid];
        out_prev_state <= dict_st[pick_tid];
      end
      if (fwd) begin
        if (upd_empty) begin
          out_prev_state[upd_fidx] <= ST_EMPTY;
        end else begin
          out_prev[upd_fidx]       <= upd_value;
          out_prev_state[upd_fidx] <= ST_ASSIGNED;
        end
      end
      if (dict_clear) out_prev_state <= '0;
    end
  end

endmodule

// File: tb/tb_fast_template_store.sv
// Directed bench for fast_template_store with hand-computed expectations.
module tb_fast_template_store;

  localparam int BEAT_W        = 64;
  localparam int NUM_TEMPLATES = 4;
  localparam int NUM_PATHS     = 4;
  localparam int FIELD_INFO_W  = 10;
  localparam int MAX_FIELDS    = 10;
  localparam int TID_W         = 2;
  localparam int FIDX_W        = 4;

  logic                                    clk;
  logic                                    rst;
  logic                                    msg_valid;
  logic                                    msg_ready;
  logic [NUM_PATHS-1:0][BEAT_W-1:0]        lane_data;
  logic [NUM_PATHS-1:0]                    lane_valid;
  logic [NUM_PATHS-1:0]                    lane_is_tid;
  logic                                    cfg_we;
  logic [TID_W-1:0]                        cfg_tid;
  logic [FIDX_W-1:0]                       cfg_fidx;
  logic [FIELD_INFO_W-1:0]                 cfg_info;
  logic                                    upd_valid;
  logic [FIDX_W-1:0]                       upd_fidx;
  logic [BEAT_W-1:0]                       upd_value;
  logic                                    upd_empty;
  logic                                    dict_clear;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [TID_W-1:0]                        out_tid;
  logic [MAX_FIELDS-1:0][FIELD_INFO_W-1:0] out_template;
  logic [MAX_FIELDS-1:0][BEAT_W-1:0]       out_prev;
  logic [MAX_FIELDS-1:0][1:0]              out_prev_state;
  logic                                    err_tid;

  int n_tests = 0;
  int n_fail  = 0;

  fast_template_store #(
    .BEAT_W        (BEAT_W),
    .NUM_TEMPLATES (NUM_TEMPLATES),
    .NUM_PATHS     (NUM_PATHS),
    .FIELD_INFO_W  (FIELD_INFO_W),
    .MAX_FIELDS    (MAX_FIELDS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .lane_data      (lane_data),
    .lane_valid     (lane_valid),
    .lane_is_tid    (lane_is_tid),
    .cfg_we         (cfg_we),
    .cfg_tid        (cfg_tid),
    .cfg_fidx       (cfg_fidx),
    .cfg_info       (cfg_info),
    .upd_valid      (upd_valid),
    .upd_fidx       (upd_fidx),
    .upd_value      (upd_value),
    .upd_empty      (upd_empty),
    .dict_clear     (dict_clear),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_tid        (out_tid),
    .out_template   (out_template),
    .out_prev       (out_prev),
    .out_prev_state (out_prev_state),
    .err_tid        (err_tid)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Descriptor written for template t, field f during configuration.
  function automatic logic [FIELD_INFO_W-1:0] tinfo(input int t, input int f);
    return FIELD_INFO_W'(t * 16 + f + 1);
  endfunction

  function automatic logic [MAX_FIELDS*FIELD_INFO_W-1:0] trow(input int t);
    logic [MAX_FIELDS-1:0][FIELD_INFO_W-1:0] r;
    for (int f = 0; f < MAX_FIELDS; f++) r[f] = tinfo(t, f);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int lane, input logic [BEAT_W-1:0] data);
    msg_valid         = 1'b1;
    lane_valid        = '0;
    lane_is_tid       = '0;
    lane_valid[lane]  = 1'b1;
    lane_is_tid[lane] = 1'b1;
    lane_data[lane]   = data;
  endtask

  task automatic set_upd(input int f, input logic [BEAT_W-1:0] v, input logic empty);
    upd_valid = 1'b1;
    upd_fidx  = FIDX_W'(f);
    upd_value = v;
    upd_empty = empty;
  endtask

  task automatic cfg_write(input int t, input int f, input logic [FIELD_INFO_W-1:0] info);
    cfg_we   = 1'b1;
    cfg_tid  = TID_W'(t);
    cfg_fidx = FIDX_W'(f);
    cfg_info = info;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; msg_valid = 1'b0; lane_data = '0; lane_valid = '0; lane_is_tid = '0;
    cfg_we = 1'b0; cfg_tid = '0; cfg_fidx = '0; cfg_info = '0;
    upd_valid = 1'b0; upd_fidx = '0; upd_value = '0; upd_empty = 1'b0;
    dict_clear = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_tid", err_tid, 0);
    chk("rst_msg_ready", msg_ready, 1);
    chk("rst_out_tid", out_tid, 0);
    chk("rst_template", out_template, 0);
    chk("rst_prev_state", out_prev_state, 0);
    rst = 1'b0;
    step();

    for (int t = 0; t < NUM_TEMPLATES; t++)
      for (int f = 0; f < MAX_FIELDS; f++) cfg_write(t, f, tinfo(t, f));

    // Lane 0 valid non-TID, lane 2 TID=3, lane 3 TID=1: lowest TID lane wins.
    msg_valid = 1'b1; lane_valid = 4'b1101; lane_is_tid = 4'b1100;
    lane_data[0] = 64'd99; lane_data[2] = 64'd3; lane_data[3] = 64'd1;
    step();
    msg_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_tid", out_tid, 3);
    chk("t1_prev_state", out_prev_state, 0);
    chk("t1_template", out_template, trow(3));
    chk("t1_msg_ready", msg_ready, 0);

    // Back-to-back accept of TID 1 while consuming, then update while PRESENT.
    out_ready = 1'b1; set_msg(0, 64'd1);
    step();
    chk("t2_out_tid", out_tid, 1);
    chk("t2_template", out_template, trow(1));
    out_ready = 1'b0; msg_valid = 1'b0;
    set_upd(4, 64'hDEAD, 1'b0);
    step();
    upd_valid = 1'b0;
    chk("t2_fwd_prev4", out_prev[4], 64'hDEAD);
    chk("t2_fwd_state4", out_prev_state[4], 2'b01);
    chk("t2_state3", out_prev_state[3], 2'b00);

    // Move to TID 2, then stall a pending TID 1 message for three cycles.
    out_ready = 1'b1; set_msg(1, 64'd2);
    step();
    chk("t3_out_tid2", out_tid, 2);
    out_ready = 1'b0; set_msg(0, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_ready", msg_ready, 0);
      chk("t3_stall_tid", out_tid, 2);
      chk("t3_stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", msg_ready, 1);
    step();
    chk("t3_load_tid", out_tid, 1);
    chk("t3_refetch_prev4", out_prev[4], 64'hDEAD);
    chk("t3_refetch_state4", out_prev_state[4], 2'b01);
    msg_valid = 1'b0;
    step();
    chk("t3_idle", out_valid, 0);

    // Out-of-range TIDs and a message with no TID lane.
    set_msg(0, 64'd5);
    step();
    msg_valid = 1'b0;
    chk("t4_err5", err_tid, 1);
    chk("t4_err5_valid", out_valid, 0);
    step();
    chk("t4_err5_pulse", err_tid, 0);
    set_msg(2, 64'd6);
    step();
    msg_valid = 1'b0;
    chk("t4_err6", err_tid, 1);
    step();
    chk("t4_err6_pulse", err_tid, 0);
    msg_valid = 1'b1; lane_valid = 4'b0011; lane_is_tid = 4'b0000;
    step();
    msg_valid = 1'b0;
    chk("t4_notid_err", err_tid, 1);
    chk("t4_notid_valid", out_valid, 0);
    chk("t4_tid_hold", out_tid, 1);
    step();
    chk("t4_notid_pulse", err_tid, 0);
    // Active TID must still be 1 (not 6 -> 2): this update lands in slot 1.
    set_upd(1, 64'h55, 1'b0);
    step();
    upd_valid = 1'b0;

    // Clear overriding a same-cycle update, then an EMPTY update.
    set_msg(0, 64'd1);
    step();
    msg_valid = 1'b0; out_ready = 1'b0;
    chk("t5_prev1", out_prev[1], 64'h55);
    chk("t5_state1", out_prev_state[1], 2'b01);
    dict_clear = 1'b1; set_upd(2, 64'h77, 1'b0);
    step();
    dict_clear = 1'b0; upd_valid = 1'b0;
    chk("t5_clear_states", out_prev_state, 0);
    chk("t5_clear_prev2", out_prev[2], 0);
    chk("t5_clear_keeps4", out_prev[4], 64'hDEAD);
    set_upd(2, 64'h99, 1'b1);
    step();
    upd_valid = 1'b0; upd_empty = 1'b0;
    chk("t5_empty_state2", out_prev_state[2], 2'b10);
    chk("t5_empty_prev2", out_prev[2], 0);
    out_ready = 1'b1;
    step();

    // Back-to-back TIDs 0, 1, 0, 0 with forwarding on the last load.
    set_msg(0, 64'd0);
    step();
    chk("t6_a_tid", out_tid, 0);
    chk("t6_a_states", out_prev_state, 0);
    set_msg(0, 64'd1); set_upd(0, 64'hAA0, 1'b0);
    step();
    upd_valid = 1'b0;
    chk("t6_b_tid", out_tid, 1);
    chk("t6_b_prev0", out_prev[0], 0);
    set_msg(0, 64'd0);
    step();
    chk("t6_c_tid", out_tid, 0);
    chk("t6_c_prev0", out_prev[0], 64'hAA0);
    chk("t6_c_state0", out_prev_state[0], 2'b01);
    set_msg(0, 64'd0); set_upd(5, 64'h123, 1'b0);
    step();
    upd_valid = 1'b0; msg_valid = 1'b0;
    chk("t6_d_valid", out_valid, 1);
    chk("t6_d_fwd_prev5", out_prev[5], 64'h123);
    chk("t6_d_fwd_state5", out_prev_state[5], 2'b01);
    step();
    chk("t6_e_idle", out_valid, 0);

    // Template write racing a load of the same TID.
    out_ready = 1'b0;
    set_msg(0, 64'd2);
    cfg_we = 1'b1; cfg_tid = 2'd2; cfg_fidx = 4'd0; cfg_info = 10'h3FF;
    step();
    cfg_we = 1'b0; msg_valid = 1'b0;
    chk("t7_old_desc", out_template[0], tinfo(2, 0));
    cfg_we = 1'b1; cfg_tid = 2'd2; cfg_fidx = 4'd1; cfg_info = 10'h2AA;
    step();
    cfg_we = 1'b0;
    chk("t7_held_desc", out_template, trow(2));
    out_ready = 1'b1; set_msg(0, 64'd2);
    step();
    msg_valid = 1'b0;
    chk("t7_new_desc0", out_template[0], 10'h3FF);
    chk("t7_new_desc1", out_template[1], 10'h2AA);
    step();

    // Asynchronous reset in the middle of a presented snapshot.
    out_ready = 1'b0; set_msg(0, 64'd1);
    step();
    msg_valid = 1'b0;
    chk("t8_present", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("t8_async_valid", out_valid, 0);
    chk("t8_async_tid", out_tid, 0);
    step();
    rst = 1'b0;
    step();
    set_msg(0, 64'd1);
    step();
    msg_valid = 1'b0;
    chk("t8_after_valid", out_valid, 1);
    chk("t8_after_prev4", out_prev[4], 0);
    chk("t8_after_states", out_prev_state, 0);
    chk("t8_after_template", out_template, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
